// File: rtl/sap1_fetch_unit.sv
// SAP-1 fetch/decode sequencer: steps T1..T5, reads instruction and operand
// words from the 16x8 RAM and hands each decoded instruction to execute.
module sap1_fetch_unit #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [DATA_W-1:0] mem_data,
   output logic              exec_valid,
   input  logic              exec_ready,
   output logic [3:0]        exec_op,
   output logic [DATA_W-1:0] exec_operand,
   output logic [ADDR_W-1:0] pc,
   output logic              halted
);

   typedef enum logic [2:0] {
      S_T1   = 3'd0,
      S_T2   = 3'd1,
      S_T3   = 3'd2,
      S_T4   = 3'd3,
      S_T5   = 3'd4,
      S_HALT = 3'd5
   } state_t;

   localparam logic [3:0]        OP_LDA = 4'h0;
   localparam logic [3:0]        OP_ADD = 4'h1;
   localparam logic [3:0]        OP_SUB = 4'h2;
   localparam logic [3:0]        OP_OUT = 4'hE;
   localparam logic [3:0]        OP_HLT = 4'hF;
   localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(1);

   function automatic logic has_operand(input logic [3:0] op);
      return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
   endfunction

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [ADDR_W-1:0]   mar_q, mar_d;
   logic [DATA_W-1:0]   ir_q, ir_d;
   logic [DATA_W-1:0]   operand_q, operand_d;
   logic                rd_en_q, rd_en_d;
   logic                valid_q, valid_d;
   logic                halted_q, halted_d;
   logic [3:0]          opcode_s;

   assign opcode_s = ir_q[DATA_W-1:DATA_W-4];

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      mar_d     = mar_q;
      ir_d      = ir_q;
      operand_d = operand_q;
      halted_d  = halted_q;
      case (state_q)
         S_T1: begin
            if (run) begin
               mar_d   = pc_q;
               state_d = S_T2;
            end else begin
               state_d = S_T1;
            end
         end
         S_T2: begin
            ir_d    = mem_data;
            pc_d    = pc_q + PC_INC;
            state_d = S_T3;
         end
         S_T3: begin
            if (has_operand(opcode_s)) begin
               mar_d   = ir_q[ADDR_W-1:0];
               state_d = S_T4;
            end else if (opcode_s == OP_OUT) begin
               operand_d = '0;
               state_d   = S_T5;
            end else if (opcode_s == OP_HLT) begin
               halted_d = 1'b1;
               state_d  = S_HALT;
            end else begin
               state_d = S_T1;
            end
         end
         S_T4: begin
            operand_d = mem_data;
            state_d   = S_T5;
         end
         S_T5: begin
            if (valid_q && exec_ready) begin
               state_d = S_T1;
            end else begin
               state_d = S_T5;
            end
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_T1;
         end
      endcase
      // Strobes are decoded from the next state so they are registered yet aligned with it.
      rd_en_d = (state_d == S_T2) || (state_d == S_T4);
      valid_d = (state_d == S_T5);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_T1;
         pc_q      <= '0;
         mar_q     <= '0;
         ir_q      <= '0;
         operand_q <= '0;
         rd_en_q   <= 1'b0;
         valid_q   <= 1'b0;
         halted_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         mar_q     <= mar_d;
         ir_q      <= ir_d;
         operand_q <= operand_d;
         rd_en_q   <= rd_en_d;
         valid_q   <= valid_d;
         halted_q  <= halted_d;
      end
   end

   assign mem_addr     = mar_q;
   assign mem_rd_en    = rd_en_q;
   assign exec_valid   = valid_q;
   assign exec_op      = opcode_s;
   assign exec_operand = operand_q;
   assign pc           = pc_q;
   assign halted       = halted_q;

endmodule

// File: tb/tb_sap1_fetch_unit.sv
// Bench for sap1_fetch_unit: per-instruction latency table, hand-written
// handshake/run/wrap/reset sequences and random programs against an ISA model.
module tb_sap1_fetch_unit;

   logic       clk = 1'b0;
   logic       rst_n, run, exec_ready, mem_rd_en, exec_valid, halted;
   logic [3:0] mem_addr, pc, exec_op;
   logic [7:0] mem_data, exec_operand, junk;
   logic [7:0] ram [16];
   logic [11:0] obs_q [$];
   logic [11:0] exp_q [$];
   int total = 0;
   int bad = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   sap1_fetch_unit #(.ADDR_W(4), .DATA_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .run(run),
      .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_data(mem_data),
      .exec_valid(exec_valid), .exec_ready(exec_ready),
      .exec_op(exec_op), .exec_operand(exec_operand),
      .pc(pc), .halted(halted)
   );

   // RAM returns garbage whenever it is not being read.
   always @(posedge clk) junk <= 8'($urandom);
   assign mem_data = mem_rd_en ? ram[mem_addr] : junk;

   always @(negedge clk)
      if (rst_n === 1'b1 && exec_valid && exec_ready) obs_q.push_back({exec_op, exec_operand});

   typedef struct {
      logic [7:0] word;
      logic [7:0] data;
      int         exp_cyc;
      logic [3:0] exp_op;
      logic [7:0] exp_opnd;
      int         exp_halt;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      cyc = 0;
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
   endtask

   task automatic fill_nops();
      for (int i = 0; i < 16; i++) ram[i] = 8'h30;
   endtask

   // Instruction-level model: walk the program from address 0 until HLT.
   task automatic model(output int fin_pc);
      int p;
      logic [7:0] w;
      logic done;
      p = 0;
      done = 1'b0;
      exp_q.delete();
      for (int k = 0; k < 64 && !done; k++) begin
         w = ram[p];
         p = (p + 1) % 16;
         if (w[7:4] <= 4'h2) exp_q.push_back({w[7:4], ram[w[3:0]]});
         else if (w[7:4] == 4'hE) exp_q.push_back({4'hE, 8'h00});
         else if (w[7:4] == 4'hF) done = 1'b1;
      end
      fin_pc = p;
   endtask

   task automatic run_program(input string name);
      int exp_pc, n, viol, idle_viol, lim;
      logic prev_stall;
      logic [3:0] prev_op, prev_pc;
      logic [7:0] prev_opnd;
      model(exp_pc);
      run = 1'b1;
      exec_ready = 1'b1;
      do_reset();
      obs_q.delete();
      n = 0; viol = 0; prev_stall = 1'b0;
      prev_op = 4'h0; prev_pc = 4'h0; prev_opnd = 8'h00;
      while (!halted && n < 3000) begin
         @(posedge clk);
         #1 exec_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         n++;
         if (prev_stall && (!exec_valid || exec_op !== prev_op ||
                            exec_operand !== prev_opnd || pc !== prev_pc)) viol++;
         prev_stall = exec_valid && !exec_ready;
         prev_op = exec_op; prev_opnd = exec_operand; prev_pc = pc;
      end
      chk({name, "_halted"}, {31'd0, halted}, 32'd1);
      chk({name, "_stall_hold"}, viol, 32'd0);
      chk({name, "_exec_count"}, obs_q.size(), exp_q.size());
      lim = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < lim; i++)
         chk($sformatf("%s_exec%0d", name, i), {20'd0, obs_q[i]}, {20'd0, exp_q[i]});
      chk({name, "_pc"}, {28'd0, pc}, exp_pc);
      idle_viol = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (mem_rd_en || exec_valid || !halted) idle_viol++;
      end
      chk({name, "_halt_idle"}, idle_viol, 32'd0);
   endtask

   initial begin
      vec_t vecs [7];
      int   exp_rd [6] = '{0, 1, 0, 1, 0, 0};
      int   exp_v  [6] = '{0, 0, 0, 0, 1, 0};
      int   first_v, first_h, viol, k, dummy;
      logic [3:0] got_op, addr_t4;
      logic [7:0] got_opnd;

      vecs[0] = '{8'h05, 8'h3C, 5, 4'h0, 8'h3C, 0};
      vecs[1] = '{8'h17, 8'hA1, 5, 4'h1, 8'hA1, 0};
      vecs[2] = '{8'h2F, 8'hFF, 5, 4'h2, 8'hFF, 0};
      vecs[3] = '{8'hE3, 8'h99, 4, 4'hE, 8'h00, 0};
      vecs[4] = '{8'h44, 8'h12, 0, 4'h0, 8'h00, 0};
      vecs[5] = '{8'hD2, 8'h55, 0, 4'h0, 8'h00, 0};
      vecs[6] = '{8'hF0, 8'hF0, 0, 4'h0, 8'h00, 4};

      run = 1'b1;
      exec_ready = 1'b1;
      rst_n = 1'b0;
      fill_nops();
      @(negedge clk);
      chk("reset_outputs", {10'd0, mem_addr, mem_rd_en, exec_valid, exec_op, exec_operand, pc, halted},
          32'd0);

      // Single LDA, cycle by cycle.
      fill_nops();
      ram[0] = 8'h09; ram[9] = 8'h14;
      do_reset();
      for (int c = 1; c <= 6; c++) begin
         step();
         chk($sformatf("lda_rd_en_c%0d", c), {31'd0, mem_rd_en}, exp_rd[c-1]);
         chk($sformatf("lda_valid_c%0d", c), {31'd0, exec_valid}, exp_v[c-1]);
         if (c == 2) chk("lda_addr_fetch", {28'd0, mem_addr}, 32'h0);
         if (c == 4) chk("lda_addr_operand", {28'd0, mem_addr}, 32'h9);
         if (c == 5) begin
            chk("lda_op", {28'd0, exec_op}, 32'h0);
            chk("lda_operand", {24'd0, exec_operand}, 32'h14);
            chk("lda_pc", {28'd0, pc}, 32'h1);
         end
      end

      // Latency table per opcode class.
      for (int i = 0; i < 7; i++) begin
         fill_nops();
         ram[vecs[i].word[3:0]] = vecs[i].data;
         ram[0] = vecs[i].word;
         exec_ready = 1'b1;
         do_reset();
         first_v = 0; first_h = 0; got_op = 4'h0; got_opnd = 8'h00;
         for (int c = 1; c <= 8; c++) begin
            step();
            if (exec_valid && first_v == 0) begin
               first_v = c; got_op = exec_op; got_opnd = exec_operand;
            end
            if (halted && first_h == 0) first_h = c;
         end
         chk($sformatf("vec%0d_exec_cycle", i), first_v, vecs[i].exp_cyc);
         chk($sformatf("vec%0d_halt_cycle", i), first_h, vecs[i].exp_halt);
         if (vecs[i].exp_cyc != 0) begin
            chk($sformatf("vec%0d_op", i), {28'd0, got_op}, {28'd0, vecs[i].exp_op});
            chk($sformatf("vec%0d_operand", i), {24'd0, got_opnd}, {24'd0, vecs[i].exp_opnd});
         end
      end

      // ADD held in T5 with exec_ready low.
      fill_nops();
      ram[0] = 8'h1A; ram[10] = 8'h55;
      exec_ready = 1'b0;
      do_reset();
      repeat (4) step();
      for (int c = 5; c <= 11; c++) begin
         step();
         chk($sformatf("stall_hold_c%0d", c), {15'd0, exec_valid, exec_op, exec_operand, pc},
             {15'd0, 1'b1, 4'h1, 8'h55, 4'h1});
      end
      exec_ready = 1'b1;
      step();
      chk("stall_release_valid", {31'd0, exec_valid}, 32'd0);
      step();
      chk("stall_next_fetch", {27'd0, mem_rd_en, mem_addr}, {27'd0, 1'b1, 4'h1});

      // run low from reset, then dropped during T3 of an LDA.
      fill_nops();
      ram[0] = 8'h09; ram[9] = 8'h14;
      run = 1'b0;
      do_reset();
      viol = 0;
      for (int c = 1; c <= 10; c++) begin
         step();
         if (mem_rd_en || pc != 4'h0) viol++;
      end
      chk("run_low_idle", viol, 32'd0);
      run = 1'b1;
      cyc = 1;
      step();
      step();
      run = 1'b0;
      step();
      step();
      chk("run_drop_exec", {19'd0, exec_valid, exec_op, exec_operand}, {19'd0, 1'b1, 4'h0, 8'h14});
      viol = 0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (mem_rd_en || exec_valid) viol++;
      end
      chk("run_drop_idle", viol, 32'd0);
      chk("run_drop_pc", {28'd0, pc}, 32'h1);
      run = 1'b1;

      // NOP fill to address 15, wrap, operand from address 5.
      fill_nops();
      ram[15] = 8'h05; ram[5] = 8'h77;
      do_reset();
      k = 0; addr_t4 = 4'h0;
      while (!exec_valid && k < 100) begin
         step();
         k++;
         if (k == 49) addr_t4 = mem_addr;
      end
      chk("wrap_exec_cycle", k, 32'd50);
      chk("wrap_operand_addr", {28'd0, addr_t4}, 32'h5);
      chk("wrap_exec", {19'd0, exec_op, exec_operand, pc}, {19'd0, 4'h0, 8'h77, 4'h0});

      // Reset asserted during T4 of a SUB.
      fill_nops();
      ram[0] = 8'h2C; ram[12] = 8'h09;
      do_reset();
      repeat (4) step();
      chk("sub_t4", {27'd0, mem_rd_en, mem_addr}, {27'd0, 1'b1, 4'hC});
      rst_n = 1'b0;
      #1;
      chk("sub_reset_outputs",
          {10'd0, mem_addr, mem_rd_en, exec_valid, exec_op, exec_operand, pc, halted}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      cyc = 0;
      step();
      step();
      chk("sub_refetch", {27'd0, mem_rd_en, mem_addr}, {27'd0, 1'b1, 4'h0});
      repeat (3) step();
      chk("sub_rerun_exec", {19'd0, exec_valid, exec_op, exec_operand}, {19'd0, 1'b1, 4'h2, 8'h09});

      // Multi-instruction program ending in HLT.
      fill_nops();
      ram[0] = 8'h09; ram[1] = 8'h1A; ram[2] = 8'hE0; ram[3] = 8'h18;
      ram[4] = 8'hE0; ram[5] = 8'h2B; ram[6] = 8'hE0; ram[7] = 8'hF0;
      ram[8] = 8'h10; ram[9] = 8'h14; ram[10] = 8'h18; ram[11] = 8'h20;
      model(dummy);
      chk("prog_model_len", exp_q.size(), 32'd7);
      run_program("prog");
      chk("prog_pc_final", {28'd0, pc}, 32'h8);

      // Random programs with a guaranteed HLT.
      for (int it = 0; it < 6; it++) begin
         for (int i = 0; i < 16; i++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 9);
            b = 8'($urandom);
            if (r < 3) b[7:4] = 4'(r);
            else if (r < 5) b[7:4] = 4'hE;
            else if (r < 7) b[7:4] = 4'(3 + $urandom_range(0, 10));
            ram[i] = b;
         end
         ram[$urandom_range(0, 15)] = 8'hF0;
         run_program($sformatf("rand%0d", it));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
